// File: rtl/tcpc_tx_scheduler_pkg.sv
// Shared definitions for the PD transmit scheduler: frame types, status codes,
// FSM state encoding and MessageID width.
package tcpc_tx_pkg;

    localparam int MSGID_W   = 3;
    localparam int TYPE_W    = 3;
    localparam int NUM_MSGID = 3;

    localparam logic [TYPE_W-1:0] FT_SOP         = 3'd0;
    localparam logic [TYPE_W-1:0] FT_SOP_P       = 3'd1;
    localparam logic [TYPE_W-1:0] FT_SOP_PP      = 3'd2;
    localparam logic [TYPE_W-1:0] FT_DBG_P       = 3'd3;
    localparam logic [TYPE_W-1:0] FT_DBG_PP      = 3'd4;
    localparam logic [TYPE_W-1:0] FT_HARD_RESET  = 3'd5;
    localparam logic [TYPE_W-1:0] FT_CABLE_RESET = 3'd6;
    localparam logic [TYPE_W-1:0] FT_BIST        = 3'd7;

    localparam logic [1:0] STAT_NONE      = 2'b00;
    localparam logic [1:0] STAT_SUCCESS   = 2'b01;
    localparam logic [1:0] STAT_FAILED    = 2'b10;
    localparam logic [1:0] STAT_DISCARDED = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_START,
        S_WAIT,
        S_REPORT
    } tx_state_e;

    // Hard/cable reset frames jump the round-robin queue.
    function automatic logic is_reset_frame(input logic [TYPE_W-1:0] t);
        return (t == FT_HARD_RESET) || (t == FT_CABLE_RESET);
    endfunction

endpackage

// File: rtl/tcpc_tx_scheduler_if.sv
// Requester + transmitter signal bundle of the scheduler; slave modport is the
// scheduler's view, master modport the surrounding logic's view.
interface tcpc_tx_scheduler_if import tcpc_tx_pkg::*; #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]        req;
    logic [TYPE_W*NUM_REQ-1:0] req_type;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        done;
    logic [1:0]                status;
    logic                      tx_start;
    logic [TYPE_W-1:0]         tx_type;
    logic [MSGID_W-1:0]        tx_msg_id;
    logic                      tx_success;
    logic                      tx_failed;
    logic                      tx_discarded;
    logic                      rx_hard_reset;

    modport slave (
        input  req, req_type, tx_success, tx_failed, tx_discarded, rx_hard_reset,
        output grant, done, status, tx_start, tx_type, tx_msg_id
    );

    modport master (
        output req, req_type, tx_success, tx_failed, tx_discarded, rx_hard_reset,
        input  grant, done, status, tx_start, tx_type, tx_msg_id
    );
endinterface

// File: rtl/tcpc_tx_scheduler_rr_arbiter.sv
// Combinational winner select: reset-class frames first (lowest index),
// otherwise round robin starting just after the previous owner.
module tcpc_tx_rr_arbiter import tcpc_tx_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [TYPE_W*NUM_REQ-1:0] i_req_type,
    input  logic [IDX_W-1:0]          i_rr_ptr,
    output logic [IDX_W-1:0]          o_idx,
    output logic                      o_valid
);
    logic [NUM_REQ-1:0] w_urgent;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_class
            assign w_urgent[gi] = i_req[gi] & is_reset_frame(i_req_type[TYPE_W*gi +: TYPE_W]);
        end
    endgenerate

    // Both scans run high-to-low so the last hit is the preferred candidate.
    always_comb begin
        int j;
        j       = 0;
        o_idx   = '0;
        o_valid = |i_req;
        if (|w_urgent) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (w_urgent[i]) o_idx = IDX_W'(i);
            end
        end else begin
            for (int k = NUM_REQ; k >= 1; k--) begin
                j = (int'(i_rr_ptr) + k) % NUM_REQ;
                if (i_req[j]) o_idx = IDX_W'(j);
            end
        end
    end
endmodule

// File: rtl/tcpc_tx_scheduler.sv
// Shares one PD transmitter among NUM_REQ requesters and owns the per-SOP MessageIDs.
// Optional TCPC_TX_WATCHDOG_EN adds a response timeout of WDOG_CYCLES in WAIT.
module tcpc_tx_scheduler import tcpc_tx_pkg::*; #(
    parameter int NUM_REQ     = 4,
    parameter int IFG_CYCLES  = 25,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset,
    tcpc_tx_scheduler_if.slave  bus
);
    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int GAP_LEN = (IFG_CYCLES < 1) ? 1 : IFG_CYCLES;
`ifdef TCPC_TX_WATCHDOG_EN
    localparam int TMR_MAX = (WDOG_CYCLES > GAP_LEN) ? WDOG_CYCLES : GAP_LEN;
`else
    localparam int TMR_MAX = GAP_LEN;
`endif
    localparam int TMR_W = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_LEN - 1);
`ifdef TCPC_TX_WATCHDOG_EN
    localparam logic [TMR_W-1:0] WDOG_LAST = TMR_W'(WDOG_CYCLES - 1);
`endif

    tx_state_e          r_state;
    logic [IDX_W-1:0]   r_owner;
    logic [TYPE_W-1:0]  r_type;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_done;
    logic [1:0]         r_status;
    logic               r_tx_start;
    logic [TYPE_W-1:0]  r_tx_type;
    logic [MSGID_W-1:0] r_tx_msg_id;
    logic [TMR_W-1:0]   r_timer;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [MSGID_W-1:0] r_msgid [NUM_MSGID];

    logic [IDX_W-1:0]   w_arb_idx;
    logic               w_arb_valid;
    logic [TYPE_W-1:0]  w_arb_type;
    logic [NUM_REQ-1:0] w_arb_1h;
    logic [NUM_REQ-1:0] w_owner_1h;
    logic               w_owner_req;
    logic [MSGID_W-1:0] w_msg_id;
    logic               w_wdog_expired;
    logic               w_report;

    tcpc_tx_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_req      (bus.req),
        .i_req_type (bus.req_type),
        .i_rr_ptr   (r_rr_ptr),
        .o_idx      (w_arb_idx),
        .o_valid    (w_arb_valid)
    );

    assign w_arb_type  = bus.req_type[TYPE_W*int'(w_arb_idx) +: TYPE_W];
    assign w_arb_1h    = NUM_REQ'(1) << w_arb_idx;
    assign w_owner_1h  = NUM_REQ'(1) << r_owner;
    assign w_owner_req = bus.req[r_owner];

`ifdef TCPC_TX_WATCHDOG_EN
    assign w_wdog_expired = (r_timer == WDOG_LAST);
`else
    assign w_wdog_expired = 1'b0;
`endif
    assign w_report = bus.rx_hard_reset | bus.tx_success | bus.tx_failed
                    | bus.tx_discarded | w_wdog_expired;

    // Only SOP/SOP'/SOP'' carry a counted MessageID; everything else sends 0.
    always_comb begin
        w_msg_id = '0;
        for (int i = 0; i < NUM_MSGID; i++) begin
            if (r_type == TYPE_W'(i)) w_msg_id = r_msgid[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_owner     <= '0;
            r_type      <= '0;
            r_grant     <= '0;
            r_done      <= '0;
            r_status    <= STAT_NONE;
            r_tx_start  <= 1'b0;
            r_tx_type   <= '0;
            r_tx_msg_id <= '0;
            r_timer     <= '0;
            r_rr_ptr    <= '0;
            for (int i = 0; i < NUM_MSGID; i++) r_msgid[i] <= '0;
        end else begin
            r_done     <= '0;
            r_tx_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_arb_valid) begin
                        r_owner <= w_arb_idx;
                        r_type  <= w_arb_type;
                        r_grant <= w_arb_1h;
                        r_timer <= '0;
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (bus.rx_hard_reset || !w_owner_req) begin
                        r_grant <= '0;
                        r_state <= S_IDLE;
                    end else if (r_timer == GAP_LAST) begin
                        r_state <= S_START;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                S_START: begin
                    if (bus.rx_hard_reset) begin
                        r_grant  <= '0;
                        r_done   <= w_owner_1h;
                        r_status <= STAT_DISCARDED;
                        r_rr_ptr <= r_owner;
                        r_state  <= S_REPORT;
                    end else begin
                        r_tx_start  <= 1'b1;
                        r_tx_type   <= r_type;
                        r_tx_msg_id <= w_msg_id;
                        r_timer     <= '0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_report) begin
                        r_grant  <= '0;
                        r_done   <= w_owner_1h;
                        r_rr_ptr <= r_owner;
                        r_state  <= S_REPORT;
                    end
                    // Outcome precedence: partner hard reset, success, failed, discarded.
                    if (bus.rx_hard_reset) begin
                        r_status <= STAT_DISCARDED;
                    end else if (bus.tx_success) begin
                        r_status <= STAT_SUCCESS;
                        for (int i = 0; i < NUM_MSGID; i++) begin
                            if (r_type == TYPE_W'(i)) r_msgid[i] <= r_msgid[i] + MSGID_W'(1);
                            if (r_type == FT_HARD_RESET) r_msgid[i] <= '0;
                            if (r_type == FT_CABLE_RESET && i != 0) r_msgid[i] <= '0;
                        end
                    end else if (bus.tx_failed) begin
                        r_status <= STAT_FAILED;
                    end else if (bus.tx_discarded) begin
                        r_status <= STAT_DISCARDED;
`ifdef TCPC_TX_WATCHDOG_EN
                    end else if (w_wdog_expired) begin
                        r_status <= STAT_FAILED;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
`endif
                    end
                end
                S_REPORT: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
            // A received hard reset wipes the MessageIDs whatever else happens this cycle.
            if (bus.rx_hard_reset) begin
                for (int i = 0; i < NUM_MSGID; i++) r_msgid[i] <= '0;
            end
        end
    end

    assign bus.grant     = r_grant;
    assign bus.done      = r_done;
    assign bus.status    = r_status;
    assign bus.tx_start  = r_tx_start;
    assign bus.tx_type   = r_tx_type;
    assign bus.tx_msg_id = r_tx_msg_id;
endmodule

// File: tb/tb_tcpc_tx_scheduler.sv
// Directed bench for tcpc_tx_scheduler: a transaction-level predictor fills a
// per-cycle expectation timeline that is compared against the DUT every cycle.
module tb_tcpc_tx_scheduler;
    import tcpc_tx_pkg::*;

    localparam int N     = 4;
    localparam int IFG   = 25;
    localparam int WDOG  = 16;
    localparam int DEPTH = 4096;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tcpc_tx_scheduler_if #(.NUM_REQ(N)) bus ();

    tcpc_tx_scheduler #(
        .NUM_REQ     (N),
        .IFG_CYCLES  (IFG),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    logic [N-1:0] exp_grant  [DEPTH];
    logic [N-1:0] exp_done   [DEPTH];
    bit           exp_txs    [DEPTH];
    logic [1:0]   exp_status [DEPTH];
    logic [2:0]   exp_type   [DEPTH];
    logic [2:0]   exp_id     [DEPTH];

    int         last_txs_cyc = -1;
    int         last_done_cyc = -1;
    logic [2:0] last_id = '0;
    logic [1:0] last_status = '0;

    logic [2:0] bt [N];
    int mcnt [3];
    int mrr = 0;

    task automatic cmp(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic check_cycle();
        if (cyc >= DEPTH) begin
            cmp("cycle_budget", cyc, DEPTH - 1);
            return;
        end
        cmp("grant", int'(bus.grant), int'(exp_grant[cyc]));
        cmp("done", int'(bus.done), int'(exp_done[cyc]));
        cmp("tx_start", int'(bus.tx_start), int'(exp_txs[cyc]));
        if (exp_txs[cyc]) begin
            cmp("tx_type", int'(bus.tx_type), int'(exp_type[cyc]));
            cmp("tx_msg_id", int'(bus.tx_msg_id), int'(exp_id[cyc]));
        end
        if (exp_done[cyc] != '0) cmp("status", int'(bus.status), int'(exp_status[cyc]));
        if (bus.tx_start) begin
            last_txs_cyc = cyc;
            last_id      = bus.tx_msg_id;
        end
        if (bus.done != '0) begin
            last_done_cyc = cyc;
            last_status   = bus.status;
        end
    endtask

    // Check the current cycle at the falling edge, then advance to just after the next rising edge.
    task automatic step();
        @(negedge clk);
        if (chk_en) check_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_type(input int i, input int t);
        bt[i] = 3'(t);
        bus.req_type[3*i +: 3] = 3'(t);
    endtask

    // Reset-class frames first (lowest index), else first requester after the last owner.
    function automatic int model_pick();
        for (int i = 0; i < N; i++)
            if (bus.req[i] && (bt[i] == 3'd5 || bt[i] == 3'd6)) return i;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (mrr + k) % N;
            if (bus.req[j]) return j;
        end
        return -1;
    endfunction

    function automatic void model_clear_all();
        for (int i = 0; i < 3; i++) mcnt[i] = 0;
    endfunction

    // oc: 0 success, 1 failed, 2 discarded, 3 success+failed, 4 none (timeout),
    //     5 partner hard reset, 6 failed+discarded.
    task automatic txn(input int delay, input int oc, input bit drop, input int post_idx, output int win);
        int a, s, w, t, id;
        logic [1:0] st;
        logic [N-1:0] oh;
        a   = cyc;
        win = model_pick();
        if (win < 0) begin
            cmp("no_requester", 0, 1);
            return;
        end
        t  = int'(bt[win]);
        id = (t <= 2) ? mcnt[t] : 0;
        s  = a + IFG + 2;
        w  = (oc == 4) ? s + WDOG - 1 : s + delay;
        case (oc)
            0, 3:    st = 2'b01;
            1, 4, 6: st = 2'b10;
            default: st = 2'b11;
        endcase
        oh = '0;
        oh[win] = 1'b1;
        for (int c = a + 1; c <= w && c < DEPTH; c++) exp_grant[c] = oh;
        if (w + 1 < DEPTH) begin
            exp_txs[s]      = 1'b1;
            exp_type[s]     = 3'(t);
            exp_id[s]       = 3'(id);
            exp_done[w + 1] = oh;
            exp_status[w + 1] = st;
        end
        step();
        step();
        // Outcome pulses while still in the gap must be ignored.
        bus.tx_success   = 1'b1;
        bus.tx_discarded = 1'b1;
        step();
        bus.tx_success   = 1'b0;
        bus.tx_discarded = 1'b0;
        while (cyc < s) step();
        if (post_idx >= 0) bus.req[post_idx] = 1'b1;
        while (cyc < w) step();
        case (oc)
            0: bus.tx_success = 1'b1;
            1: bus.tx_failed = 1'b1;
            2: bus.tx_discarded = 1'b1;
            3: begin bus.tx_success = 1'b1; bus.tx_failed = 1'b1; end
            5: bus.rx_hard_reset = 1'b1;
            6: begin bus.tx_failed = 1'b1; bus.tx_discarded = 1'b1; end
            default: ;
        endcase
        step();
        bus.tx_success    = 1'b0;
        bus.tx_failed     = 1'b0;
        bus.tx_discarded  = 1'b0;
        bus.rx_hard_reset = 1'b0;
        if (drop) bus.req[win] = 1'b0;
        if (oc == 0 || oc == 3) begin
            if (t <= 2) mcnt[t] = (mcnt[t] + 1) % 8;
            if (t == 5) model_clear_all();
            if (t == 6) begin mcnt[1] = 0; mcnt[2] = 0; end
        end
        if (oc == 5) model_clear_all();
        mrr = win;
        step();
    endtask

    // Abort in the gap after 'off' granted cycles, by partner hard reset or owner dropping req.
    task automatic gap_abort(input int off, input bit use_hr);
        int a, win;
        logic [N-1:0] oh;
        a   = cyc;
        win = model_pick();
        oh  = '0;
        if (win >= 0) oh[win] = 1'b1;
        for (int c = a + 1; c <= a + off && c < DEPTH; c++) exp_grant[c] = oh;
        while (cyc < a + off) step();
        if (use_hr) bus.rx_hard_reset = 1'b1;
        else if (win >= 0) bus.req[win] = 1'b0;
        step();
        bus.rx_hard_reset = 1'b0;
        if (use_hr) model_clear_all();
    endtask

    initial begin
        int w, a0, saved_txs;
        int winners [7];
        int exp_w [7];
        int oc_list [4];
        int oc_stat [4];
        exp_w   = '{1, 2, 1, 2, 3, 1, 2};
        oc_list = '{1, 2, 3, 6};
        oc_stat = '{2, 3, 1, 2};
        for (int c = 0; c < DEPTH; c++) begin
            exp_grant[c] = '0; exp_done[c] = '0; exp_txs[c] = 1'b0;
            exp_status[c] = '0; exp_type[c] = '0; exp_id[c] = '0;
        end
        bus.req = '0; bus.req_type = '0;
        bus.tx_success = 1'b0; bus.tx_failed = 1'b0;
        bus.tx_discarded = 1'b0; bus.rx_hard_reset = 1'b0;
        for (int i = 0; i < N; i++) bt[i] = '0;
        model_clear_all();

        reset = 1'b1;
        repeat (3) step();
        cmp("rst_grant", int'(bus.grant), 0);
        cmp("rst_done", int'(bus.done), 0);
        cmp("rst_tx_start", int'(bus.tx_start), 0);
        cmp("rst_status", int'(bus.status), 0);
        cmp("rst_tx_type", int'(bus.tx_type), 0);
        cmp("rst_tx_msg_id", int'(bus.tx_msg_id), 0);
        reset  = 1'b0;
        chk_en = 1'b1;
        repeat (3) step();

        // Single SOP from requester 0.
        set_type(0, 0);
        bus.req[0] = 1'b1;
        a0 = cyc;
        txn(3, 0, 1'b1, -1, w);
        cmp("t1_latency", last_txs_cyc - a0, 27);
        cmp("t1_owner", w, 0);
        cmp("t1_id", int'(last_id), 0);
        cmp("t1_status", int'(last_status), 1);

        // Round robin 1/2, hard reset from 3 posted mid-stream wins next.
        set_type(1, 0); set_type(2, 0); set_type(3, 5);
        bus.req[1] = 1'b1; bus.req[2] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            txn(2, 0, (i >= 4), (i == 3) ? 3 : -1, w);
            winners[i] = w;
            cmp("rr_winner", winners[i], exp_w[i]);
        end
        cmp("sop_after_hard_reset", int'(last_id), 1);

        // Nine SOP' sends wrap the SOP' counter.
        set_type(0, 1);
        for (int i = 0; i < 9; i++) begin
            bus.req[0] = 1'b1;
            txn(1, 0, 1'b1, -1, w);
            cmp("sopp_id", int'(last_id), i % 8);
        end
        set_type(0, 0);
        bus.req[0] = 1'b1;
        txn(1, 0, 1'b1, -1, w);
        cmp("sop_untouched", int'(last_id), 2);

        // Outcome encodings and precedence.
        for (int i = 0; i < 4; i++) begin
            bus.req[0] = 1'b1;
            txn(i + 1, oc_list[i], 1'b1, -1, w);
            cmp("outcome_status", int'(last_status), oc_stat[i]);
        end

        // DBG' sends id 0; cable reset clears SOP'/SOP'' only.
        set_type(0, 1); bus.req[0] = 1'b1; txn(0, 0, 1'b1, -1, w);
        set_type(0, 3); bus.req[0] = 1'b1; txn(0, 0, 1'b1, -1, w);
        cmp("dbg_id", int'(last_id), 0);
        set_type(0, 6); bus.req[0] = 1'b1; txn(0, 0, 1'b1, -1, w);
        set_type(0, 1); bus.req[0] = 1'b1; txn(0, 0, 1'b1, -1, w);
        cmp("sopp_after_cable_reset", int'(last_id), 0);
        set_type(0, 0); bus.req[0] = 1'b1; txn(0, 0, 1'b1, -1, w);
        cmp("sop_after_cable_reset", int'(last_id), 4);

        // Partner hard reset while waiting for the outcome.
        bus.req[0] = 1'b1; txn(4, 5, 1'b1, -1, w);
        cmp("rx_hr_wait_status", int'(last_status), 3);
        bus.req[0] = 1'b1; txn(0, 0, 1'b1, -1, w);
        cmp("sop_after_rx_hr", int'(last_id), 0);

        // Partner hard reset in the gap: no done, counters cleared, request re-arbitrated.
        bus.req[0] = 1'b1;
        gap_abort(5, 1'b1);
        txn(2, 0, 1'b1, -1, w);
        cmp("sop_after_gap_hr", int'(last_id), 0);

        // Owner withdraws in the gap: nothing reaches the transmitter.
        saved_txs  = last_txs_cyc;
        bus.req[0] = 1'b1;
        gap_abort(10, 1'b0);
        repeat (5) step();
        cmp("gap_drop_no_start", last_txs_cyc, saved_txs);

`ifdef TCPC_TX_WATCHDOG_EN
        bus.req[0] = 1'b1;
        txn(0, 4, 1'b1, -1, w);
        cmp("wdog_latency", last_done_cyc - last_txs_cyc, 16);
        cmp("wdog_status", int'(last_status), 2);
`endif

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
